odometer_meas_ctrl: RTL

ODOMETER_MEAS_CTRL -- requirements
Module: odometer_meas_ctrl

---
 rtl/odometer_pkg.sv | 20 ++
 rtl/odometer_edge_cnt.sv | 51 +++++
 rtl/odometer_meas_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/odometer_pkg.sv
// Shared definitions for the ring-oscillator odometer measurement controller.
// Holds the run-sequencer state encoding and fixed timing constants.
package odometer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STRESS  = 3'd1,
        SETTLE  = 3'd2,
        MEASURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int SETTLE_CYCLES = 4;
    localparam int SYNC_STAGES   = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/odometer_edge_cnt.sv
// One oscillator channel: synchronizer, rising-edge detector and saturating
// edge counter. The next count is exported so the parent can capture it losslessly.
module odometer_edge_cnt
    import odometer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ro_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_nxt_o,
    output logic             sat_nxt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && rise && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ro_i};
            prev_q  <= sync_q[SYNC_STAGES-1];
            count_q <= count_d;
        end
    end

    assign count_nxt_o = count_d;
    assign sat_nxt_o   = (count_d == CNT_MAX);

endmodule

// File: rtl/odometer_meas_ctrl.sv
// Stress-then-measure sequencer for a reference/stressed ring-oscillator pair.
// Define ODOMETER_DIFF_EN to add the signed cnt_diff (str - ref) output.
module odometer_meas_ctrl
    import odometer_pkg::*;
#(
    parameter int WIN_W = 16,
    parameter int CNT_W = 16,
    parameter int STR_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [STR_W-1:0]        stress_len,
    input  logic [WIN_W-1:0]        win_len,
    input  logic                    ro_ref_in,
    input  logic                    ro_str_in,
    output logic                    ro_ref_en,
    output logic                    ro_str_en,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf,
    output logic [CNT_W-1:0]        cnt_ref,
    output logic [CNT_W-1:0]        cnt_str,
`ifdef ODOMETER_DIFF_EN
    output logic signed [CNT_W:0]   cnt_diff,
`endif
    output state_e                  dbg_state
);

    // One down-counter serves every timed phase, so it spans the widest length.
    localparam int TMR_W = max_int(max_int(STR_W, WIN_W), 3);

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic              accept;
    logic              timer_last;

    logic              ref_en_q, ref_en_d;
    logic              str_en_q, str_en_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_ref_q, cnt_ref_d;
    logic [CNT_W-1:0]  cnt_str_q, cnt_str_d;

    logic [CNT_W-1:0]  ref_nxt, str_nxt;
    logic              ref_sat, str_sat;
    logic              meas_en, settle_clr;

    assign accept     = (state_q == IDLE) && start;
    assign timer_last = (timer_q == TMR_W'(1));
    assign meas_en    = (state_q == MEASURE);
    assign settle_clr = (state_q == SETTLE);

    odometer_edge_cnt #(.CNT_W(CNT_W)) u_ref_cnt (
        .clk         (clk),
        .rst         (rst),
        .ro_i        (ro_ref_in),
        .en_i        (meas_en),
        .clr_i       (settle_clr),
        .count_nxt_o (ref_nxt),
        .sat_nxt_o   (ref_sat)
    );

    odometer_edge_cnt #(.CNT_W(CNT_W)) u_str_cnt (
        .clk         (clk),
        .rst         (rst),
        .ro_i        (ro_str_in),
        .en_i        (meas_en),
        .clr_i       (settle_clr),
        .count_nxt_o (str_nxt),
        .sat_nxt_o   (str_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        win_d   = win_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    win_d = win_len;
                    if (stress_len != '0) begin
                        state_d = STRESS;
                        timer_d = TMR_W'(stress_len);
                    end else begin
                        state_d = SETTLE;
                        timer_d = TMR_W'(SETTLE_CYCLES);
                    end
                end
            end
            STRESS: begin
                if (timer_last) begin
                    state_d = SETTLE;
                    timer_d = TMR_W'(SETTLE_CYCLES);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            SETTLE: begin
                if (timer_last) begin
                    state_d = (win_q == '0) ? DONE : MEASURE;
                    timer_d = TMR_W'(win_q);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            MEASURE: begin
                if (timer_last) begin
                    state_d = DONE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // Outputs are decoded from the next state so the registered enables and
    // done line up exactly with the state they belong to.
    always_comb begin
        ref_en_d  = (state_d == SETTLE) || (state_d == MEASURE);
        str_en_d  = (state_d == STRESS) || (state_d == SETTLE) || (state_d == MEASURE);
        done_d    = (state_d == DONE);
        cnt_ref_d = cnt_ref_q;
        cnt_str_d = cnt_str_q;
        ovf_d     = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (meas_en && (ref_sat || str_sat)) begin
            ovf_d = 1'b1;
        end
        if (done_d) begin
            cnt_ref_d = ref_nxt;
            cnt_str_d = str_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_en_q  <= 1'b0;
            str_en_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_ref_q <= '0;
            cnt_str_q <= '0;
        end else begin
            ref_en_q  <= ref_en_d;
            str_en_q  <= str_en_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            cnt_ref_q <= cnt_ref_d;
            cnt_str_q <= cnt_str_d;
        end
    end

`ifdef ODOMETER_DIFF_EN
    logic signed [CNT_W:0] diff_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q <= '0;
        end else if (done_d) begin
            diff_q <= $signed({1'b0, str_nxt}) - $signed({1'b0, ref_nxt});
        end
    end

    assign cnt_diff = diff_q;
`endif

    assign ro_ref_en = ref_en_q;
    assign ro_str_en = str_en_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign cnt_ref   = cnt_ref_q;
    assign cnt_str   = cnt_str_q;
    assign dbg_state = state_q;

endmodule
